// File: rtl/display_scanner.sv
// Probe-channel BCD converter with a multiplexed, active-low 4-digit
// seven-segment scanner.
module display_scanner #(
  parameter int NUM_CH      = 12,
  parameter int REFRESH_DIV = 100000,
  parameter int LZ_BLANK    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [$clog2(NUM_CH)-1:0] ssd_sel,
  input  logic [NUM_CH*32-1:0]      ch_data,
  input  logic                      freeze,
  output logic [3:0]                anode,
  output logic [6:0]                seg,
  output logic [15:0]               digits_bcd,
  output logic                      conv_done
);

  localparam int SW = $clog2(NUM_CH);
  localparam int RW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [12:0]   sh_q, sh_d;
  logic [15:0]   acc_q, acc_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   dig_q, dig_d;
  logic          done_q, done_d;
  logic [RW-1:0] rc_q, rc_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic [12:0]   val;
  logic [15:0]   adj;
  logic [3:0]    nib;
  logic          blank;
  logic          unused_bits;

  function automatic logic [6:0] enc(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Out-of-range selects fall through to zero.
  always_comb begin
    val = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ssd_sel == SW'(k)) begin
        val = ch_data[32*k +: 13];
      end
    end
  end

  always_comb begin
    adj = acc_q;
    for (int n = 0; n < 4; n++) begin
      if (acc_q[4*n +: 4] >= 4'd5) begin
        adj[4*n +: 4] = acc_q[4*n +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    bit_d   = bit_q;
    dig_d   = dig_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        sh_d    = val;
        acc_d   = '0;
        bit_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        acc_d = {adj[14:0], sh_q[12]};
        sh_d  = {sh_q[11:0], 1'b0};
        bit_d = bit_q + 4'd1;
        if (bit_q == 4'd12) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!freeze) begin
          dig_d  = acc_q;
          done_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Segments follow next-state digits so they always match digits_bcd.
  always_comb begin
    rc_d  = rc_q + RW'(1);
    idx_d = idx_q;
    if (rc_q == RW'(REFRESH_DIV - 1)) begin
      rc_d  = '0;
      idx_d = idx_q + 2'd1;
    end
    an_d  = ~(4'b0001 << idx_d);
    nib   = dig_d[{idx_d, 2'b00} +: 4];
    blank = (LZ_BLANK != 0) && (idx_d != 2'd0) &&
            ((dig_d >> {idx_d, 2'b00}) == 16'h0);
    seg_d = blank ? 7'h7F : enc(nib);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      acc_q   <= '0;
      bit_q   <= '0;
      dig_q   <= '0;
      done_q  <= 1'b0;
      rc_q    <= '0;
      idx_q   <= '0;
      an_q    <= 4'b1110;
      seg_q   <= 7'h40;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      bit_q   <= bit_d;
      dig_q   <= dig_d;
      done_q  <= done_d;
      rc_q    <= rc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign unused_bits = ^{ch_data, adj[15]};

  assign anode      = an_q;
  assign seg        = seg_q;
  assign digits_bcd = dig_q;
  assign conv_done  = done_q;

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner: conversions, scan sequence,
// freeze and mid-conversion reset.
module tb_display_scanner;

  localparam int NCH  = 12;
  localparam int RDIV = 4;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic [3:0]        ssd_sel;
  logic [NCH*32-1:0] ch_data;
  logic              freeze;
  logic [3:0]        anode;
  logic [6:0]        seg;
  logic [15:0]       digits_bcd;
  logic              conv_done;

  logic [31:0] ch [NCH];

  display_scanner #(
    .NUM_CH     (NCH),
    .REFRESH_DIV(RDIV),
    .LZ_BLANK   (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ssd_sel   (ssd_sel),
    .ch_data   (ch_data),
    .freeze    (freeze),
    .anode     (anode),
    .seg       (seg),
    .digits_bcd(digits_bcd),
    .conv_done (conv_done)
  );

  always #5 clk = ~clk;

  always_comb begin
    ch_data = '0;
    for (int k = 0; k < NCH; k++) ch_data[32*k +: 32] = ch[k];
  end

  int vecs = 0;
  int errs = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10),
            4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seg_exp(input logic [15:0] d,
                                         input logic [1:0] i);
    logic [3:0] n;
    n = d[4*i +: 4];
    if (i != 2'd0 && (d >> (4 * i)) == 16'h0) return 7'h7F;
    case (n)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic int cur_val();
    if (int'(ssd_sel) < NCH) return int'(ch[ssd_sel][12:0]);
    return 0;
  endfunction

  logic [15:0] q [$];
  int          cyc      = 0;
  int          rcnt     = 0;
  logic [1:0]  idx      = 2'd0;
  logic        exp_done = 1'b0;
  logic [15:0] mdig     = 16'h0;
  logic [15:0] e;
  logic [3:0]  an_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      cyc      = 0;
      rcnt     = 0;
      idx      = 2'd0;
      exp_done = 1'b0;
      mdig     = 16'h0;
    end else begin
      cyc++;
      exp_done = 1'b0;
      if (cyc % 15 == 1) q.push_back(to_bcd(cur_val()));
      if (cyc % 15 == 0) begin
        if (!freeze) begin
          exp_done = 1'b1;
          if (q.size() > 0) mdig = q[0];
        end else if (q.size() > 0) begin
          void'(q.pop_front());
        end
      end
      if (rcnt == RDIV - 1) begin
        rcnt = 0;
        idx++;
      end else begin
        rcnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("conv_done", 32'(conv_done), 32'(exp_done));
      if (conv_done) begin
        if (q.size() == 0) begin
          check("queue", 32'(q.size()), 32'd1);
        end else begin
          e = q.pop_front();
          check("digits_bcd", 32'(digits_bcd), 32'(e));
        end
      end
      an_e = ~(4'b0001 << idx);
      check("anode", 32'(anode), 32'(an_e));
      check("seg", 32'(seg), 32'(seg_exp(mdig, idx)));
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_anode"}, 32'(anode), 32'h0000_000E);
    check({tag, "_seg"}, 32'(seg), 32'h0000_0040);
    check({tag, "_bcd"}, 32'(digits_bcd), 32'h0);
    check({tag, "_done"}, 32'(conv_done), 32'h0);
  endtask

  task automatic wait_phase(input int ph);
    int n;
    n = 0;
    while (cyc % 15 != ph && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("align", 32'(cyc % 15), 32'(ph));
  endtask

  initial begin
    freeze  = 1'b0;
    ssd_sel = 4'd3;
    for (int k = 0; k < NCH; k++) ch[k] = 32'h0;
    ch[3] = 32'h0000_04D2;

    @(negedge clk);
    #1 check_reset("rst0");
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("first_done", 32'(conv_done), 32'h1);
    check("first_bcd", 32'(digits_bcd), 32'h1234);

    @(negedge clk);
    ch[3] = 32'hFFFF_FFFF;
    run(32);
    check("max_bcd", 32'(digits_bcd), 32'h8191);

    ssd_sel = 4'd12;
    run(48);
    check("oob_zero", 32'(digits_bcd), 32'h0);
    ssd_sel = 4'd6;
    ch[6]   = 32'hFFFF_E000;
    run(48);
    check("hi_bits", 32'(digits_bcd), 32'h0);

    ssd_sel = 4'd5;
    ch[5]   = 32'd205;
    run(48);
    check("scan_val", 32'(digits_bcd), 32'h0205);

    ch[1]   = 32'd42;
    ch[2]   = 32'd7;
    ssd_sel = 4'd1;
    run(32);
    wait_phase(5);
    ssd_sel = 4'd2;
    run(32);
    check("sel_swap", 32'(digits_bcd), 32'h0007);

    ssd_sel = 4'd4;
    ch[4]   = 32'd100;
    run(32);
    freeze = 1'b1;
    ch[4]  = 32'd200;
    run(45);
    check("frozen", 32'(digits_bcd), 32'h0100);
    freeze = 1'b0;
    run(32);
    check("thawed", 32'(digits_bcd), 32'h0200);

    for (int i = 0; i < 40; i++) begin
      ch[$urandom_range(0, NCH - 1)] = $urandom;
      ssd_sel = 4'($urandom_range(0, 13));
      freeze  = ($urandom_range(0, 3) == 0);
      run($urandom_range(1, 20));
    end
    freeze = 1'b0;
    ssd_sel = 4'd3;
    ch[3]   = 32'd8191;
    run(32);

    wait_phase(7);
    #2 rst_n = 1'b0;
    #1 check_reset("rst_mid");
    @(negedge clk);
    #2 rst_n = 1'b1;
    run(32);
    check("post_rst", 32'(digits_bcd), 32'h8191);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 SHALL have parameter NUM_CH, default 12: number of 32-bit probe channels.
REQ-002 SHALL have parameter REFRESH_DIV, default 100000: clk cycles per digit scan slot; legal range ≥ 2.
REQ-003 SHALL have parameter LZ_BLANK, default 1: 1 blanks leading zeros, 0 shows all four digits.
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port ssd_sel, input, $clog2(NUM_CH): channel select.
REQ-007 SHALL have port ch_data, input, NUM_CH*32: packed channels; channel k is bits [32k+31:32k].
REQ-008 SHALL have port freeze, input, 1: 1 holds the displayed digits.
REQ-009 SHALL have port anode, output, 4: active-low one-hot digit enable; bit 0 is the rightmost (ones) digit.
REQ-010 SHALL have port seg, output, 7: active-low segments, order {g,f,e,d,c,b,a}.
REQ-011 SHALL have port digits_bcd, output, 16: registered BCD of the displayed value; [3:0] is ones.
REQ-012 SHALL have port conv_done, output, 1: one-cycle pulse when digits_bcd updates.

Function
REQ-013 Value source SHALL be ch_data channel ssd_sel bits [12:0]; ssd_sel ≥ NUM_CH SHALL select value 0.
REQ-014 Converter FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-015 IDLE SHALL capture the 13-bit value into a shift register, clear the 16-bit BCD accumulator and go to SHIFT, all in one cycle; no other IDLE exit.
REQ-016 SHIFT SHALL run exactly 13 cycles of sequential double-dabble: add 3 to each BCD nibble ≥ 5, then shift left one bit from the value MSB.
REQ-017 After the 13th SHIFT cycle the FSM SHALL enter DONE.
REQ-018 DONE SHALL load digits_bcd from the accumulator and pulse conv_done, unless freeze=1; then go to IDLE.
REQ-019 DONE with freeze=1 SHALL leave digits_bcd unchanged and keep conv_done low.
REQ-020 Conversion period SHALL be 15 cycles (IDLE 1 + SHIFT 13 + DONE 1), repeating continuously.
REQ-021 Latency from a value sampled in IDLE to digits_bcd update SHALL be 15 rising edges.
REQ-022 Changes to ssd_sel or ch_data during SHIFT/DONE SHALL NOT affect the in-flight conversion.
REQ-023 Maximum value 8191 SHALL yield BCD 16'h8191; every nibble SHALL always be ≤ 9.
REQ-024 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap.
REQ-025 On each wrap the 2-bit digit index SHALL increment, with 3 wrapping to 0.
REQ-026 anode SHALL equal ~(4'b0001 << index), registered.
REQ-027 seg SHALL encode digits_bcd nibble [index]: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
REQ-028 seg SHALL be registered and change in the same cycle as anode.
REQ-029 With LZ_BLANK=1, digit i>0 SHALL show seg=7'h7F when nibble i and all higher nibbles are 0.
REQ-030 Digit 0 SHALL never be blanked.
REQ-031 freeze SHALL NOT stop scanning.

Reset
REQ-032 rst_n=0 SHALL immediately force: FSM=IDLE, refresh counter=0, index=0, digits_bcd=16'h0000, conv_done=0, anode=4'b1110, seg=7'h40.
REQ-033 Reset during SHIFT SHALL abort the conversion with no digits_bcd update.
REQ-034 After rst_n deasserts, the first IDLE SHALL occur on the first rising edge.

Verification
REQ-035 Scenario: channel 3 = 32'h0000_04D2, ssd_sel=3, run 15 cycles after reset -> conv_done pulse, digits_bcd=16'h1234.
REQ-036 Scenario: value 13'h1FFF -> digits_bcd=16'h8191; value 0 with LZ_BLANK=1 -> digits 3..1 seg=7'h7F, digit 0 seg=7'h40.
REQ-037 Scenario: REFRESH_DIV=4, digits_bcd=16'h0205 -> anode sequence 1110,1101,1011,0111 every 4 cycles; seg=7'h12, 7'h40, 7'h24, 7'h7F.
REQ-038 Scenario: ssd_sel changed mid-SHIFT from a channel holding 42 to one holding 7 -> next update shows 16'h0042, following update shows 16'h0007.
REQ-039 Scenario: freeze=1 while the channel changes 100->200 -> digits_bcd stays 16'h0100 with no conv_done; freeze=0 -> 16'h0200 within 15 cycles.
REQ-040 Scenario: rst_n pulsed low at SHIFT cycle 6 -> all outputs at reset values immediately; next conv_done exactly 15 cycles after release.
